// File: rtl/mmu_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmu_bus_responder
// Purpose  : Bus-side responder for the phi2 timing generated by the MMU
//            sequencer. Decodes a 16-byte register window at BASE, drives read
//            data while the access is active (plus HOLD clocks after phi2
//            falls), commits writes on the phi2 falling edge, and exposes the
//            page-mapping registers to the address mapper.
// Ports    : fpgaClk  - system clock (also the source of phi2)
//            resetN   - synchronous active-low reset
//            phi2     - bus phase from the sequencer
//            a        - CPU address bus (16 bits)
//            rw       - 1 = read, 0 = write
//            dIn      - CPU write data
//            dOut     - read data to CPU
//            dOe      - data output enable to the bus transceiver
//            pageIdx  - mapper lookup index
//            pageOut  - register[pageIdx]; index 15 returns the access counter
// Revision : 1.0 - initial release
// ============================================================================
module mmu_bus_responder #(
  parameter logic [15:0] BASE = 16'hDE00,  // low nibble must be zero
  parameter int unsigned HOLD = 1          // 1..7 clocks of dOe after phi2 falls
) (
  input  logic        fpgaClk,
  input  logic        resetN,
  input  logic        phi2,
  input  logic [15:0] a,
  input  logic        rw,
  input  logic [7:0]  dIn,
  output logic [7:0]  dOut,
  output logic        dOe,
  input  logic [3:0]  pageIdx,
  output logic [7:0]  pageOut
);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_ACTIVE    = 2'd1;
  localparam logic [1:0] c_HOLDST    = 2'd2;
  localparam logic [2:0] c_HOLD_INIT = 3'(HOLD - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_stateNext;
  logic             r_phi2Prev;
  logic [3:0]       r_idxL;
  logic             r_rwL;
  logic             r_hitL;
  logic [2:0]       r_holdCnt;
  logic             r_dOe;
  logic [7:0]       r_dOut;
  logic [7:0]       r_hitCount;
  logic [14:0][7:0] r_pages;

  logic             w_rise;
  logic             w_fall;
  logic             w_hit;
  logic             w_latch;
  logic             w_dOeNext;
  logic [7:0]       w_dOutNext;
  logic [2:0]       w_holdNext;
  logic             w_wrEn;
  logic             w_cntInc;
  logic             w_cntClr;

  // Register file view: entries 0..14 are page registers, entry 15 is the counter.
  function automatic logic [7:0] f_lookup(input logic [3:0] idx,
                                          input logic [14:0][7:0] pages,
                                          input logic [7:0] cnt);
    f_lookup = cnt;
    for (int i = 0; i < 15; i++) begin
      if (idx == 4'(i)) f_lookup = pages[i];
    end
  endfunction

  assign w_rise  = phi2 & ~r_phi2Prev;
  assign w_fall  = ~phi2 & r_phi2Prev;
  assign w_hit   = (a[15:4] == BASE[15:4]);
  assign pageOut = f_lookup(pageIdx, r_pages, r_hitCount);
  assign dOut    = r_dOut;
  // A new access arriving while the previous one is still holding the bus
  // releases the transceiver immediately in the rise cycle.
  assign dOe     = r_dOe & ~((r_state == c_HOLDST) & w_rise);

  // State register and datapath registers
  always_ff @(posedge fpgaClk) begin
    if (!resetN) begin
      r_state    <= c_IDLE;
      r_phi2Prev <= 1'b1;   // phi2 already high at release is not a rise
      r_idxL     <= 4'd0;
      r_rwL      <= 1'b0;
      r_hitL     <= 1'b0;
      r_holdCnt  <= 3'd0;
      r_dOe      <= 1'b0;
      r_dOut     <= 8'd0;
      r_hitCount <= 8'd0;
      for (int i = 0; i < 15; i++) r_pages[i] <= 8'(i);
    end else begin
      r_state    <= w_stateNext;
      r_phi2Prev <= phi2;
      if (w_latch) begin
        r_idxL <= a[3:0];
        r_rwL  <= rw;
        r_hitL <= w_hit;
      end
      r_holdCnt <= w_holdNext;
      r_dOe     <= w_dOeNext;
      r_dOut    <= w_dOutNext;
      if (w_cntClr)      r_hitCount <= 8'd0;
      else if (w_cntInc) r_hitCount <= r_hitCount + 8'd1;
      if (w_wrEn) begin
        for (int i = 0; i < 15; i++) begin
          if (r_idxL == 4'(i)) r_pages[i] <= dIn;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_IDLE:   if (w_rise) w_stateNext = c_ACTIVE;
      c_ACTIVE: if (w_fall) w_stateNext = r_hitL ? c_HOLDST : c_IDLE;
      c_HOLDST: begin
        if (w_rise)                 w_stateNext = c_ACTIVE;
        else if (r_holdCnt == 3'd0) w_stateNext = c_IDLE;
      end
      default:  w_stateNext = c_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    w_latch    = 1'b0;
    w_dOeNext  = r_dOe;
    w_dOutNext = r_dOut;
    w_holdNext = r_holdCnt;
    w_wrEn     = 1'b0;
    w_cntInc   = 1'b0;
    w_cntClr   = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_rise) begin
          // Registered read data must be valid on the first ACTIVE cycle, so
          // it is taken from the live address in the rise cycle.
          w_latch   = 1'b1;
          w_dOeNext = w_hit & rw;
          if (w_hit & rw) w_dOutNext = f_lookup(a[3:0], r_pages, r_hitCount);
        end
      end
      c_ACTIVE: begin
        if (r_hitL & r_rwL) begin
          w_dOeNext  = 1'b1;
          w_dOutNext = f_lookup(r_idxL, r_pages, r_hitCount);
        end
        if (w_fall) begin
          if (r_hitL) begin
            w_wrEn     = ~r_rwL;
            // Writing the counter slot clears it; the clear beats the increment.
            w_cntClr   = ~r_rwL & (r_idxL == 4'hF);
            w_cntInc   = ~w_cntClr;
            w_holdNext = c_HOLD_INIT;
          end else begin
            w_dOeNext = 1'b0;
          end
        end
      end
      c_HOLDST: begin
        if (w_rise) begin
          w_latch   = 1'b1;
          w_dOeNext = w_hit & rw;
          if (w_hit & rw) w_dOutNext = f_lookup(a[3:0], r_pages, r_hitCount);
        end else if (r_holdCnt == 3'd0) begin
          w_dOeNext = 1'b0;
        end else begin
          w_holdNext = r_holdCnt - 3'd1;
        end
      end
      default: w_dOeNext = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mmu_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmu_bus_responder
// Purpose  : Self-checking bench for mmu_bus_responder. One instance with
//            HOLD = 1 carries the table-driven accesses and the read-data
//            scoreboard; a second instance with HOLD = 7 shares the stimulus
//            and is checked for the long hold and the hold-abort case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmu_bus_responder;

  logic        fpgaClk = 1'b0;
  logic        resetN;
  logic        phi2;
  logic [15:0] a;
  logic        rw;
  logic [7:0]  dIn;
  logic [3:0]  pageIdx;
  logic [7:0]  dOut1, dOut7, pageOut1, pageOut7;
  logic        dOe1, dOe7;

  int checks   = 0;
  int failures = 0;

  logic [7:0] expQ[$];
  logic       prevOe1 = 1'b0;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  din;
    logic        expRead;   // hit read: dOe window and scoreboard entry expected
    logic [7:0]  expData;
    logic [3:0]  idx;       // pageIdx watched during the access
    logic [7:0]  expOld;    // pageOut[idx] in the fall cycle
    logic [7:0]  expNew;    // pageOut[idx] one cycle after fall
    logic [7:0]  expCnt;    // hitCount after the access
  } vec_t;

  vec_t tbl [0:12];

  always #5 fpgaClk = ~fpgaClk;

  mmu_bus_responder #(.BASE(16'hDE00), .HOLD(1)) u_dut1 (
    .fpgaClk(fpgaClk), .resetN(resetN), .phi2(phi2), .a(a), .rw(rw),
    .dIn(dIn), .dOut(dOut1), .dOe(dOe1), .pageIdx(pageIdx), .pageOut(pageOut1)
  );

  mmu_bus_responder #(.BASE(16'hDE00), .HOLD(7)) u_dut7 (
    .fpgaClk(fpgaClk), .resetN(resetN), .phi2(phi2), .a(a), .rw(rw),
    .dIn(dIn), .dOut(dOut7), .dOe(dOe7), .pageIdx(pageIdx), .pageOut(pageOut7)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] addr, input logic r, input logic [7:0] din,
                              input logic er, input logic [7:0] ed, input logic [3:0] idx,
                              input logic [7:0] eo, input logic [7:0] en, input logic [7:0] ec);
    vec_t v;
    v.addr = addr; v.rw = r; v.din = din; v.expRead = er; v.expData = ed;
    v.idx = idx; v.expOld = eo; v.expNew = en; v.expCnt = ec;
    return v;
  endfunction

  // Scoreboard: each new dOe assertion on the HOLD=1 instance consumes one
  // expected read value.
  always @(negedge fpgaClk) begin
    if (dOe1 && !prevOe1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected dOe: dOut=%0h, expected no read", dOut1);
      end else begin
        chk("read data", {24'd0, dOut1}, {24'd0, expQ.pop_front()});
      end
    end
    prevOe1 = dOe1;
  end

  task automatic stepCycle(input logic p);
    @(posedge fpgaClk);
    #1;
    phi2 = p;
    @(negedge fpgaClk);
  endtask

  // One full phi2 period: rise in cycle 0, fall in cycle 5.
  task automatic runAccess(input vec_t v);
    logic [9:0] mask;
    logic [7:0] pOld, pNew;
    mask = '0;
    pOld = '0;
    pNew = '0;
    a = v.addr; rw = v.rw; dIn = v.din; pageIdx = v.idx;
    if (v.expRead) expQ.push_back(v.expData);
    for (int k = 0; k < 10; k++) begin
      stepCycle(k < 5);
      mask[k] = dOe1;
      if (k == 5) pOld = pageOut1;
      if (k == 6) pNew = pageOut1;
    end
    chk($sformatf("dOe window %h", v.addr), {22'd0, mask}, v.expRead ? 32'h07E : 32'h0);
    chk($sformatf("pageOut old %h", v.addr), {24'd0, pOld}, {24'd0, v.expOld});
    chk($sformatf("pageOut new %h", v.addr), {24'd0, pNew}, {24'd0, v.expNew});
    pageIdx = 4'hF;
    #1;
    chk($sformatf("hitCount %h", v.addr), {24'd0, pageOut1}, {24'd0, v.expCnt});
  endtask

  initial begin
    //          addr      rw    din    read  data   idx    old    new    cnt
    tbl[0]  = mk(16'hDE03, 1'b0, 8'hA7, 1'b0, 8'h00, 4'h3, 8'h03, 8'hA7, 8'h01);
    tbl[1]  = mk(16'hDE03, 1'b1, 8'h00, 1'b1, 8'hA7, 4'h3, 8'hA7, 8'hA7, 8'h02);
    tbl[2]  = mk(16'hDF03, 1'b1, 8'h00, 1'b0, 8'h00, 4'h3, 8'hA7, 8'hA7, 8'h02);
    tbl[3]  = mk(16'hDF03, 1'b0, 8'h11, 1'b0, 8'h00, 4'h3, 8'hA7, 8'hA7, 8'h02);
    tbl[4]  = mk(16'hDE0A, 1'b0, 8'h5C, 1'b0, 8'h00, 4'hA, 8'h0A, 8'h5C, 8'h03);
    tbl[5]  = mk(16'hDE0A, 1'b1, 8'h00, 1'b1, 8'h5C, 4'hA, 8'h5C, 8'h5C, 8'h04);
    tbl[6]  = mk(16'hDE0F, 1'b1, 8'h00, 1'b1, 8'h04, 4'hF, 8'h04, 8'h05, 8'h05);
    tbl[7]  = mk(16'hDDFF, 1'b1, 8'h00, 1'b0, 8'h00, 4'h0, 8'h00, 8'h00, 8'h05);
    tbl[8]  = mk(16'hDE00, 1'b0, 8'h3C, 1'b0, 8'h00, 4'h0, 8'h00, 8'h3C, 8'h06);
    tbl[9]  = mk(16'hDE07, 1'b1, 8'h00, 1'b1, 8'h07, 4'h7, 8'h07, 8'h07, 8'h07);
    tbl[10] = mk(16'hDE00, 1'b1, 8'h00, 1'b1, 8'h3C, 4'h0, 8'h3C, 8'h3C, 8'h08);
    tbl[11] = mk(16'hDE0E, 1'b0, 8'h99, 1'b0, 8'h00, 4'hE, 8'h0E, 8'h99, 8'h09);
    tbl[12] = mk(16'hDE0E, 1'b1, 8'h00, 1'b1, 8'h99, 4'hE, 8'h99, 8'h99, 8'h0A);

    // Reset with phi2 high and a hit write presented: nothing may happen
    // until a genuine rising edge.
    resetN = 1'b0; phi2 = 1'b1; a = 16'hDE03; rw = 1'b0; dIn = 8'hFF; pageIdx = 4'h5;
    repeat (3) @(posedge fpgaClk);
    #1 resetN = 1'b1;
    repeat (3) @(posedge fpgaClk);
    #1 phi2 = 1'b0;
    repeat (3) @(posedge fpgaClk);
    @(negedge fpgaClk);
    chk("reset dOe", {31'd0, dOe1}, 32'd0);
    chk("reset dOut", {24'd0, dOut1}, 32'd0);
    chk("reset dOe hold7", {31'd0, dOe7}, 32'd0);
    chk("reset page5", {24'd0, pageOut1}, 32'h05);
    pageIdx = 4'h3; #1;
    chk("reset page3", {24'd0, pageOut1}, 32'h03);
    pageIdx = 4'hF; #1;
    chk("reset hitCount", {24'd0, pageOut1}, 32'h00);

    for (int i = 0; i < 13; i++) runAccess(tbl[i]);

    // Counter wrap: clear, 256 reads, clear beats increment, count read at rise.
    runAccess(mk(16'hDE0F, 1'b0, 8'hAA, 1'b0, 8'h00, 4'hF, 8'h0A, 8'h00, 8'h00));
    for (int k = 0; k < 256; k++) begin
      runAccess(mk(16'hDE00, 1'b1, 8'h00, 1'b1, 8'h3C, 4'h0, 8'h3C, 8'h3C, 8'(k + 1)));
    end
    runAccess(mk(16'hDE0F, 1'b0, 8'h77, 1'b0, 8'h00, 4'hF, 8'h00, 8'h00, 8'h00));
    runAccess(mk(16'hDE0F, 1'b1, 8'h00, 1'b1, 8'h00, 4'hF, 8'h00, 8'h01, 8'h01));

    // Reset coinciding with the fall of a write: nothing is committed.
    a = 16'hDE02; rw = 1'b0; dIn = 8'h55; pageIdx = 4'h2;
    for (int k = 0; k < 5; k++) stepCycle(1'b1);
    @(posedge fpgaClk);
    #1 phi2 = 1'b0; resetN = 1'b0;
    @(posedge fpgaClk);
    #1 resetN = 1'b1;
    @(negedge fpgaClk);
    chk("reset-on-fall page2", {24'd0, pageOut1}, 32'h02);
    chk("reset-on-fall page2 hold7", {24'd0, pageOut7}, 32'h02);
    chk("reset-on-fall dOe", {31'd0, dOe1}, 32'd0);
    pageIdx = 4'h0; #1;
    chk("reset-on-fall page0", {24'd0, pageOut1}, 32'h00);
    pageIdx = 4'hF; #1;
    chk("reset-on-fall hitCount", {24'd0, pageOut1}, 32'h00);
    stepCycle(1'b0);
    stepCycle(1'b0);
    runAccess(mk(16'hDE02, 1'b1, 8'h00, 1'b1, 8'h02, 4'h2, 8'h02, 8'h02, 8'h01));

    // HOLD = 7: the second read's rise lands inside the first read's hold.
    for (int k = 0; k < 8; k++) stepCycle(1'b0);
    a = 16'hDE04; rw = 1'b1; pageIdx = 4'h0;
    expQ.push_back(8'h04);
    for (int k = 0; k < 25; k++) begin
      if (k == 10) begin
        a = 16'hDE06;
        expQ.push_back(8'h06);
      end
      stepCycle((k < 5) || (k >= 10 && k < 15));
      if (k == 9)  begin
        chk("hold7 dOe before abort", {31'd0, dOe7}, 32'd1);
        chk("hold7 dOut before abort", {24'd0, dOut7}, 32'h04);
      end
      if (k == 10) chk("hold7 dOe on abort rise", {31'd0, dOe7}, 32'd0);
      if (k == 11) begin
        chk("hold7 dOe new read", {31'd0, dOe7}, 32'd1);
        chk("hold7 dOut new read", {24'd0, dOut7}, 32'h06);
      end
      if (k == 22) chk("hold7 dOe last hold cycle", {31'd0, dOe7}, 32'd1);
      if (k == 23) begin
        chk("hold7 dOe released", {31'd0, dOe7}, 32'd0);
        chk("hold7 dOut kept", {24'd0, dOut7}, 32'h06);
      end
    end

    chk("scoreboard drained", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
